door_access_ctrl: RTL and testbench

DOOR_ACCESS_CTRL -- requirements
Module: door_access_ctrl

---
 rtl/door_pkg.sv | 22 ++
 rtl/keypad_collector.sv | 53 +++++
 rtl/door_access_ctrl.sv | 139 +++++++++++++
 tb/tb_door_access_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/door_pkg.sv
// Shared types and sizing for the door access controller and its keypad collectors.
package door_pkg;

  localparam int unsigned DIGITS      = 3;
  localparam int unsigned CODE_W      = 12;
  localparam int unsigned NUM_KEYPADS = 2;
  localparam int unsigned DIGIT_W     = CODE_W / DIGITS;
  localparam int unsigned CNT_W       = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESULT,
    ST_OPEN,
    ST_LOCKOUT
  } door_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_collector.sv
// One keypad's digit buffer: shifts digits in MSB-first, flags full at DIGITS,
// and clears on request (clear always wins over a new digit).
module keypad_collector
  import door_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               key_valid_i,
  input  logic [DIGIT_W-1:0] key_data_i,
  input  logic               clr_i,
  output logic [CODE_W-1:0]  code_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o
);

  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full;

  assign full = (cnt_q == CNT_W'(DIGITS));

  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      code_d = '0;
      cnt_d  = '0;
    end else if (key_valid_i && !full) begin
      case (cnt_q)
        2'd0:    code_d[CODE_W-1 -: DIGIT_W]         = key_data_i;
        2'd1:    code_d[CODE_W-1-DIGIT_W -: DIGIT_W] = key_data_i;
        2'd2:    code_d[DIGIT_W-1:0]                 = key_data_i;
        default: code_d = code_q;
      endcase
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else begin
      code_q <= code_d;
      cnt_q  <= cnt_d;
    end
  end

  assign code_o  = code_q;
  assign count_o = cnt_q;
  assign full_o  = full;

endmodule

// File: rtl/door_access_ctrl.sv
// Two-keypad door controller: round-robin arbitration of full keypads, code
// issue to an external checker, then timed door-open or alarm lockout.
module door_access_ctrl
  import door_pkg::*;
#(
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_KEYPADS-1:0] key_valid,
  input  logic [DIGIT_W-1:0]     key_data0,
  input  logic [DIGIT_W-1:0]     key_data1,
  input  logic [NUM_KEYPADS-1:0] key_clr,
  input  logic                   access,
  input  logic                   alram,
  output logic [CODE_W-1:0]      passin,
  output logic                   enter,
  output logic                   door_open,
  output logic                   open_port,
  output logic                   lockout,
  output logic [CNT_W-1:0]       digits0,
  output logic [CNT_W-1:0]       digits1
);

  localparam int unsigned DWELL_W = $clog2(max_u(OPEN_CYCLES, LOCK_CYCLES)) + 1;

  door_state_e       state_q;
  logic [CODE_W-1:0] passin_q;
  logic              enter_q;
  logic              door_open_q;
  logic              open_port_q;
  logic              lockout_q;
  logic              last_q;
  logic [DWELL_W-1:0] dwell_q;

  logic [DIGIT_W-1:0]     kdata [NUM_KEYPADS];
  logic [CODE_W-1:0]      code  [NUM_KEYPADS];
  logic [CNT_W-1:0]       count [NUM_KEYPADS];
  logic [NUM_KEYPADS-1:0] req;
  logic [NUM_KEYPADS-1:0] issue_clr;
  logic [NUM_KEYPADS-1:0] kp_clr;
  logic                   grant;

  assign kdata[0] = key_data0;
  assign kdata[1] = key_data1;

  // The served keypad is cleared on the edge leaving ISSUE; LOCKOUT holds both clear.
  assign issue_clr = (state_q == ST_ISSUE) ? (open_port_q ? 2'b10 : 2'b01) : 2'b00;
  assign kp_clr    = key_clr | issue_clr | {NUM_KEYPADS{state_q == ST_LOCKOUT}};

  for (genvar p = 0; p < NUM_KEYPADS; p++) begin : g_kp
    keypad_collector u_kp (
      .clk_i       (clk),
      .reset_i     (reset),
      .key_valid_i (key_valid[p]),
      .key_data_i  (kdata[p]),
      .clr_i       (kp_clr[p]),
      .code_o      (code[p]),
      .count_o     (count[p]),
      .full_o      (req[p])
    );
  end

  always_comb begin
    grant = req[1];
    if (req == 2'b11) grant = ~last_q;
  end

  // passin is captured at the grant edge, so a key_clr landing on that same
  // edge cannot cancel the issue already under way.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      passin_q    <= '0;
      enter_q     <= 1'b0;
      door_open_q <= 1'b0;
      open_port_q <= 1'b0;
      lockout_q   <= 1'b0;
      last_q      <= 1'b1;
      dwell_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q     <= ST_ISSUE;
            enter_q     <= 1'b1;
            passin_q    <= code[grant];
            open_port_q <= grant;
            last_q      <= grant;
          end
        end
        ST_ISSUE: begin
          enter_q <= 1'b0;
          state_q <= ST_RESULT;
        end
        ST_RESULT: begin
          if (alram) begin
            state_q   <= ST_LOCKOUT;
            lockout_q <= 1'b1;
            dwell_q   <= DWELL_W'(LOCK_CYCLES - 1);
          end else if (access) begin
            state_q     <= ST_OPEN;
            door_open_q <= 1'b1;
            dwell_q     <= DWELL_W'(OPEN_CYCLES - 1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_OPEN: begin
          if (dwell_q == '0) begin
            state_q     <= ST_IDLE;
            door_open_q <= 1'b0;
          end else begin
            dwell_q <= dwell_q - 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (dwell_q == '0) begin
            state_q   <= ST_IDLE;
            lockout_q <= 1'b0;
          end else begin
            dwell_q <= dwell_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign passin    = passin_q;
  assign enter     = enter_q;
  assign door_open = door_open_q;
  assign open_port = open_port_q;
  assign lockout   = lockout_q;
  assign digits0   = count[0];
  assign digits1   = count[1];

endmodule

// File: tb/tb_door_access_ctrl.sv
// Scoreboard bench for door_access_ctrl: stimulus queues expected issue/open/lockout
// events, a negedge monitor rebuilds observed events and compares them in order.
module tb_door_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  key_valid;
  logic [3:0]  key_data0, key_data1;
  logic [1:0]  key_clr;
  logic        access, alram;
  logic [11:0] passin;
  logic        enter, door_open, open_port, lockout;
  logic [1:0]  digits0, digits1;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_ISSUE, EV_OPEN, EV_LOCK} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [11:0] code;
    logic        port;
    int          len;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  door_access_ctrl #(.OPEN_CYCLES(8), .LOCK_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_data0 (key_data0),
    .key_data1 (key_data1),
    .key_clr   (key_clr),
    .access    (access),
    .alram     (alram),
    .passin    (passin),
    .enter     (enter),
    .door_open (door_open),
    .open_port (open_port),
    .lockout   (lockout),
    .digits0   (digits0),
    .digits1   (digits1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [11:0] c, input logic p, input int l);
    ev_t e;
    e.kind = k; e.code = c; e.port = p; e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_t o);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d code %0h port %0d len %0d expected none",
               o.kind, o.code, o.port, o.len);
    end else begin
      e = exp_q.pop_front();
      if (o.kind != e.kind ||
          (e.kind == EV_ISSUE && (o.code !== e.code || o.port !== e.port)) ||
          (e.kind != EV_ISSUE && o.len != e.len)) begin
        errors++;
        $display("FAIL event: got kind %0d code %0h port %0d len %0d expected kind %0d code %0h port %0d len %0d",
                 o.kind, o.code, o.port, o.len, e.kind, e.code, e.port, e.len);
      end
    end
  endtask

  // Monitor: an enter pulse is one issue event; door_open/lockout runs are
  // measured in cycles and reported when they fall.
  initial begin
    int  open_run;
    int  lock_run;
    ev_t o;
    open_run = 0;
    lock_run = 0;
    forever begin
      @(negedge clk);
      if (enter === 1'b1) begin
        o.kind = EV_ISSUE; o.code = passin; o.port = open_port; o.len = 1;
        observe(o);
      end
      if (door_open === 1'b1) open_run++;
      else if (open_run > 0) begin
        o.kind = EV_OPEN; o.code = '0; o.port = 1'b0; o.len = open_run;
        observe(o);
        open_run = 0;
      end
      if (lockout === 1'b1) lock_run++;
      else if (lock_run > 0) begin
        o.kind = EV_LOCK; o.code = '0; o.port = 1'b0; o.len = lock_run;
        observe(o);
        lock_run = 0;
      end
    end
  end

  task automatic key(input logic [1:0] v, input logic [3:0] d0, input logic [3:0] d1);
    key_valid = v;
    key_data0 = d0;
    key_data1 = d1;
    tick();
    key_valid = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1; key_valid = '0; key_data0 = '0; key_data1 = '0;
    key_clr = '0; access = 1'b0; alram = 1'b0;
    tick();
    tick();
    check("rst_passin", 32'(passin), 0);
    check("rst_enter", 32'(enter), 0);
    check("rst_door_open", 32'(door_open), 0);
    check("rst_open_port", 32'(open_port), 0);
    check("rst_lockout", 32'(lockout), 0);
    check("rst_digits0", 32'(digits0), 0);
    check("rst_digits1", 32'(digits1), 0);
    reset = 1'b0;

    // Keypad 0 enters A8C, checker grants access.
    access = 1'b1; alram = 1'b0;
    expect_ev(EV_ISSUE, 12'hA8C, 1'b0, 0);
    expect_ev(EV_OPEN, 12'h000, 1'b0, 8);
    key(2'b01, 4'hA, 4'h0);
    key(2'b01, 4'h8, 4'h0);
    key(2'b01, 4'hC, 4'h0);
    check("a_digits0_full", 32'(digits0), 3);
    check("a_enter_not_yet", 32'(enter), 0);
    tick();
    check("a_enter_latency", 32'(enter), 1);
    check("a_passin", 32'(passin), 32'hA8C);
    repeat (14) tick();
    check("a_digits0_cleared", 32'(digits0), 0);
    check("a_door_closed", 32'(door_open), 0);

    // Both keypads full on the same edge after reset: keypad 0 first.
    do_reset();
    access = 1'b0; alram = 1'b0;
    expect_ev(EV_ISSUE, 12'h123, 1'b0, 0);
    expect_ev(EV_ISSUE, 12'h456, 1'b1, 0);
    key(2'b11, 4'h1, 4'h4);
    key(2'b11, 4'h2, 4'h5);
    key(2'b11, 4'h3, 4'h6);
    repeat (8) tick();
    check("b_digits0", 32'(digits0), 0);
    check("b_digits1", 32'(digits1), 0);

    // Alarm on keypad 1: lockout, keys ignored throughout.
    access = 1'b0; alram = 1'b1;
    expect_ev(EV_ISSUE, 12'h789, 1'b1, 0);
    expect_ev(EV_LOCK, 12'h000, 1'b0, 16);
    key(2'b10, 4'h0, 4'h7);
    key(2'b10, 4'h0, 4'h8);
    key(2'b10, 4'h0, 4'h9);
    tick();
    tick();
    tick();
    check("c_lockout_high", 32'(lockout), 1);
    key_valid = 2'b11; key_data0 = 4'h5; key_data1 = 4'h5;
    tick();
    tick();
    key_valid = 2'b00;
    check("c_digits0_locked", 32'(digits0), 0);
    check("c_digits1_locked", 32'(digits1), 0);
    repeat (20) tick();
    check("c_lockout_done", 32'(lockout), 0);
    check("c_digits1_after", 32'(digits1), 0);

    // access and alram together: alarm wins.
    access = 1'b1; alram = 1'b1;
    expect_ev(EV_ISSUE, 12'h001, 1'b0, 0);
    expect_ev(EV_LOCK, 12'h000, 1'b0, 16);
    key(2'b01, 4'h0, 4'h0);
    key(2'b01, 4'h0, 4'h0);
    key(2'b01, 4'h1, 4'h0);
    tick();
    tick();
    tick();
    check("d_lockout_high", 32'(lockout), 1);
    check("d_door_closed", 32'(door_open), 0);
    repeat (20) tick();

    // Clear and digit together on keypad 1: clear wins.
    access = 1'b0; alram = 1'b0;
    key(2'b10, 4'h0, 4'h3);
    key(2'b10, 4'h0, 4'h4);
    check("e_digits1_two", 32'(digits1), 2);
    key_clr = 2'b10;
    key(2'b10, 4'h0, 4'h5);
    key_clr = 2'b00;
    check("e_digits1_clr", 32'(digits1), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("e_no_enter", 32'(enter), 0);
    end

    // Reset during the third OPEN cycle truncates the pulse.
    access = 1'b1; alram = 1'b0;
    expect_ev(EV_ISSUE, 12'h321, 1'b1, 0);
    expect_ev(EV_OPEN, 12'h000, 1'b0, 3);
    key(2'b10, 4'h0, 4'h3);
    key(2'b10, 4'h0, 4'h2);
    key(2'b10, 4'h0, 4'h1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (door_open === 1'b1) seen = 1'b1;
      else tick();
    end
    check("f_door_opened", 32'(seen), 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("f_rst_door_open", 32'(door_open), 0);
    check("f_rst_passin", 32'(passin), 0);
    check("f_rst_open_port", 32'(open_port), 0);
    check("f_rst_enter", 32'(enter), 0);
    check("f_rst_lockout", 32'(lockout), 0);
    check("f_rst_digits1", 32'(digits1), 0);
    reset = 1'b0;
    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
